// File: rtl/hazard_if.sv
// Bundle of pipeline-facing signals for hazard_ctrl: ID operand info, branch/memory status in,
// stage enables, flush/bubble, forwarding selects and perf counters out.
`timescale 1ns/1ps
interface hazard_if #(
  parameter int unsigned PERF_W = 16
);
  logic              id_valid_inst;
  logic [4:0]        id_rs1_idx;
  logic              id_rs1_used;
  logic [4:0]        id_rs2_idx;
  logic              id_rs2_used;
  logic [4:0]        id_dest_reg_idx;
  logic              id_reg_wr;
  logic              id_rd_mem;
  logic              ex_take_branch;
  logic              mem_busy;

  logic              pc_enable;
  logic              if_id_enable;
  logic              if_id_flush;
  logic              id_ex_enable;
  logic              id_ex_bubble;
  logic              ex_mem_enable;
  logic              mem_wb_enable;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [1:0]        ctrl_state;
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_flush_cnt;

  // Pipeline side
  modport master (
    output id_valid_inst, id_rs1_idx, id_rs1_used, id_rs2_idx, id_rs2_used,
           id_dest_reg_idx, id_reg_wr, id_rd_mem, ex_take_branch, mem_busy,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble,
           ex_mem_enable, mem_wb_enable, fwd_a_sel, fwd_b_sel, ctrl_state,
           perf_stall_cnt, perf_flush_cnt
  );

  // Hazard controller side
  modport slave (
    input  id_valid_inst, id_rs1_idx, id_rs1_used, id_rs2_idx, id_rs2_used,
           id_dest_reg_idx, id_reg_wr, id_rd_mem, ex_take_branch, mem_busy,
    output pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble,
           ex_mem_enable, mem_wb_enable, fwd_a_sel, fwd_b_sel, ctrl_state,
           perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: scoreboard-based RAW stalls, branch flush, memory freeze.
// Optional macro FORWARDING_EN enables EX-operand bypass selects and load-use-only stalls.
`timescale 1ns/1ps
module hazard_ctrl #(
  parameter int unsigned PERF_W = 16
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StStall  = 2'd1,
    StFlush  = 2'd2,
    StFreeze = 2'd3
  } ctrl_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } slot_t;

  slot_t             ex_q, mem_q, wb_q, ex_d;
  ctrl_e             state_q, state_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hit_rs1, hit_rs2, raw;
  logic pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_bub, ex_mem_en, mem_wb_en;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic slot_hit(slot_t s, logic [4:0] r);
    return s.valid && (s.dest == r);
  endfunction

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwd_pick(slot_t m, slot_t w, logic [4:0] r);
    if (slot_hit(m, r)) begin
      return 2'b01;
    end else if (slot_hit(w, r)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  // Only a load still in EX cannot be bypassed in time.
  assign hit_rs1 = slot_hit(ex_q, hz.id_rs1_idx) && ex_q.is_load;
  assign hit_rs2 = slot_hit(ex_q, hz.id_rs2_idx) && ex_q.is_load;
  // Unused source fields were stored as x0, which never matches a valid writer.
  assign fwd_a   = fwd_pick(mem_q, wb_q, ex_q.rs1);
  assign fwd_b   = fwd_pick(mem_q, wb_q, ex_q.rs2);
`else
  assign hit_rs1 = slot_hit(ex_q, hz.id_rs1_idx) || slot_hit(mem_q, hz.id_rs1_idx) ||
                   slot_hit(wb_q, hz.id_rs1_idx);
  assign hit_rs2 = slot_hit(ex_q, hz.id_rs2_idx) || slot_hit(mem_q, hz.id_rs2_idx) ||
                   slot_hit(wb_q, hz.id_rs2_idx);
  assign fwd_a   = 2'b00;
  assign fwd_b   = 2'b00;

  logic unused_ex_fields;
  assign unused_ex_fields = ^{ex_q.is_load, ex_q.rs1, ex_q.rs2};
`endif

  logic unused_fields;
  assign unused_fields = ^{mem_q.is_load, mem_q.rs1, mem_q.rs2, wb_q.is_load, wb_q.rs1, wb_q.rs2};

  assign raw = (hz.id_rs1_used && (hz.id_rs1_idx != 5'd0) && hit_rs1) ||
               (hz.id_rs2_used && (hz.id_rs2_idx != 5'd0) && hit_rs2);

  always_comb begin
    state_d     = StRun;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_fl    = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_bub   = 1'b0;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (hz.mem_busy) begin
      state_d   = StFreeze;
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (hz.ex_take_branch) begin
      // ID holds wrong-path work, so any RAW it shows is irrelevant.
      state_d     = StFlush;
      if_id_fl    = 1'b1;
      id_ex_bub   = 1'b1;
      flush_cnt_d = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + PERF_W'(1);
    end else if (raw && hz.id_valid_inst) begin
      state_d     = StStall;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_bub   = 1'b1;
      stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + PERF_W'(1);
    end
  end

  always_comb begin
    ex_d = '0;
    if (!id_ex_bub && hz.id_valid_inst) begin
      ex_d.valid   = hz.id_reg_wr && (hz.id_dest_reg_idx != 5'd0);
      ex_d.dest    = hz.id_dest_reg_idx;
      ex_d.is_load = hz.id_rd_mem;
      ex_d.rs1     = hz.id_rs1_used ? hz.id_rs1_idx : 5'd0;
      ex_d.rs2     = hz.id_rs2_used ? hz.id_rs2_idx : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= StRun;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      if (state_d != StFreeze) begin
        ex_q  <= ex_d;
        mem_q <= ex_q;
        wb_q  <= mem_q;
      end
    end
  end

  assign hz.pc_enable      = pc_en;
  assign hz.if_id_enable   = if_id_en;
  assign hz.if_id_flush    = if_id_fl;
  assign hz.id_ex_enable   = id_ex_en;
  assign hz.id_ex_bubble   = id_ex_bub;
  assign hz.ex_mem_enable  = ex_mem_en;
  assign hz.mem_wb_enable  = mem_wb_en;
  assign hz.fwd_a_sel      = fwd_a;
  assign hz.fwd_b_sel      = fwd_b;
  assign hz.ctrl_state     = state_q;
  assign hz.perf_stall_cnt = stall_cnt_q;
  assign hz.perf_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, RAW stalls, branch flush, freeze, x0 rules, saturation.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam logic [6:0] EnRun    = 7'b1101011;
  localparam logic [6:0] EnStall  = 7'b0001111;
  localparam logic [6:0] EnFlush  = 7'b1111111;
  localparam logic [6:0] EnFreeze = 7'b0000000;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad = 0;

  hazard_if #(.PERF_W(16)) hz ();

  hazard_ctrl #(.PERF_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] en_vec();
    return {hz.pc_enable, hz.if_id_enable, hz.if_id_flush, hz.id_ex_enable,
            hz.id_ex_bubble, hz.ex_mem_enable, hz.mem_wb_enable};
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld);
    hz.id_valid_inst   = v;
    hz.id_rs1_idx      = rs1;
    hz.id_rs1_used     = u1;
    hz.id_rs2_idx      = rs2;
    hz.id_rs2_used     = u2;
    hz.id_dest_reg_idx = rd;
    hz.id_reg_wr       = wr;
    hz.id_rd_mem       = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    hz.ex_take_branch = 1'b0;
    hz.mem_busy       = 1'b0;
  endtask

  // Advance to the next negedge and let combinational outputs settle.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (3) cyc();
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // T1 reset
    repeat (2) @(posedge clk);
    cyc(); #1;
    chk("rst_en", 32'(en_vec()), 32'(EnRun));
    chk("rst_state", 32'(hz.ctrl_state), 0);
    chk("rst_stall_cnt", 32'(hz.perf_stall_cnt), 0);
    chk("rst_flush_cnt", 32'(hz.perf_flush_cnt), 0);
    chk("rst_fwd", 32'({hz.fwd_a_sel, hz.fwd_b_sel}), 0);
    rst = 1'b0;
    drain();

`ifndef FORWARDING_EN
    // T2 back-to-back RAW: 3 stalls
    cyc(); set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); #1;
    chk("t2_producer_en", 32'(en_vec()), 32'(EnRun));
    cyc(); set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    chk("t2_stall1_en", 32'(en_vec()), 32'(EnStall));
    cyc(); #1;
    chk("t2_stall2_en", 32'(en_vec()), 32'(EnStall));
    chk("t2_stall2_state", 32'(hz.ctrl_state), 1);
    cyc(); #1;
    chk("t2_stall3_en", 32'(en_vec()), 32'(EnStall));
    cyc(); #1;
    chk("t2_resume_en", 32'(en_vec()), 32'(EnRun));
    chk("t2_stall_cnt", 32'(hz.perf_stall_cnt), 3);
    chk("t2_fwd_tied", 32'({hz.fwd_a_sel, hz.fwd_b_sel}), 0);
    drain();
    chk("t2_state_run", 32'(hz.ctrl_state), 0);
`else
    // T3 load-use costs one stall; non-load producer is bypassed from MEM
    cyc(); set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1); #1;
    cyc(); set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    chk("t3_loaduse_stall", 32'(en_vec()), 32'(EnStall));
    cyc(); #1;
    chk("t3_loaduse_resume", 32'(en_vec()), 32'(EnRun));
    cyc(); idle(); #1;
    chk("t3_load_fwd_a", 32'(hz.fwd_a_sel), 2);
    drain();
    cyc(); set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); #1;
    cyc(); set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    chk("t3_alu_no_stall", 32'(en_vec()), 32'(EnRun));
    cyc(); idle(); #1;
    chk("t3_alu_fwd_a", 32'(hz.fwd_a_sel), 1);
    chk("t3_alu_fwd_b", 32'(hz.fwd_b_sel), 0);
    chk("t3_stall_cnt", 32'(hz.perf_stall_cnt), 1);
    drain();
`endif

    // T4 branch taken while ID has a RAW (load producer: stalls in either build)
    cyc(); set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); #1;
    cyc(); set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0); #1;
    chk("t4_raw_stall", 32'(en_vec()), 32'(EnStall));
    cyc(); hz.ex_take_branch = 1'b1; #1;
    chk("t4_flush_en", 32'(en_vec()), 32'(EnFlush));
    cyc(); idle(); #1;
    chk("t4_state_flush", 32'(hz.ctrl_state), 2);
    chk("t4_flush_cnt", 32'(hz.perf_flush_cnt), 1);
    drain();

`ifndef FORWARDING_EN
    // T5 freeze 4 cycles in the middle of a 3-cycle stall
    cyc(); set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); #1;
    cyc(); set_id(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0); #1;
    chk("t5_stall_first", 32'(en_vec()), 32'(EnStall));
    for (int i = 0; i < 4; i++) begin
      cyc(); hz.mem_busy = 1'b1; #1;
      chk("t5_freeze_en", 32'(en_vec()), 32'(EnFreeze));
    end
    chk("t5_freeze_state", 32'(hz.ctrl_state), 3);
    chk("t5_freeze_cnt_hold", 32'(hz.perf_stall_cnt), 5);
    cyc(); hz.mem_busy = 1'b0; #1;
    chk("t5_resume_stall2", 32'(en_vec()), 32'(EnStall));
    cyc(); #1;
    chk("t5_resume_stall3", 32'(en_vec()), 32'(EnStall));
    cyc(); #1;
    chk("t5_resume_run", 32'(en_vec()), 32'(EnRun));
    chk("t5_stall_cnt", 32'(hz.perf_stall_cnt), 7);
    drain();
`endif

    // Reset during a stall leaves nothing pending
    cyc(); set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); #1;
    cyc(); set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); #1;
    chk("rs_pre_stall", 32'(en_vec()), 32'(EnStall));
    cyc(); rst = 1'b1; #1;
    cyc(); rst = 1'b0; #1;
    chk("rs_no_pending", 32'(en_vec()), 32'(EnRun));
    chk("rs_state", 32'(hz.ctrl_state), 0);
    chk("rs_stall_cnt", 32'(hz.perf_stall_cnt), 0);
    chk("rs_flush_cnt", 32'(hz.perf_flush_cnt), 0);
    drain();

    // T6 x0 destinations, unused sources, invalid ID, non-writing producer
    cyc(); set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); #1;
    cyc(); set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0); #1;
    chk("t6_x0_no_stall", 32'(en_vec()), 32'(EnRun));
    cyc(); set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1); #1;
    cyc(); set_id(1'b1, 5'd12, 1'b0, 5'd12, 1'b0, 5'd13, 1'b1, 1'b0); #1;
    chk("t6_unused_no_stall", 32'(en_vec()), 32'(EnRun));
    cyc(); set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1); #1;
    cyc(); set_id(1'b0, 5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0); #1;
    chk("t6_invalid_no_stall", 32'(en_vec()), 32'(EnRun));
    drain();
    cyc(); set_id(1'b1, 5'd1, 1'b1, 5'd16, 1'b1, 5'd16, 1'b0, 1'b1); #1;
    cyc(); set_id(1'b1, 5'd16, 1'b1, 5'd0, 1'b0, 5'd17, 1'b1, 1'b0); #1;
    chk("t6_nowrite_no_stall", 32'(en_vec()), 32'(EnRun));
    chk("t6_stall_cnt", 32'(hz.perf_stall_cnt), 0);
    drain();

    // Flush counter saturation
    cyc(); hz.ex_take_branch = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_near_max", 32'(hz.perf_flush_cnt), 32'hFFFE);
    @(posedge clk); #1;
    chk("sat_at_max", 32'(hz.perf_flush_cnt), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", 32'(hz.perf_flush_cnt), 32'hFFFF);
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
